// File: rtl/button_reader.sv
// Debounced push-button reader: per-button synchroniser and debounce FSM with
// press/release/long pulses, plus a 4-entry event FIFO fed lowest-index first.
module button_reader #(
  parameter int NBTN            = 4,
  parameter int DEBOUNCE_CYCLES = 33000,
  parameter int LONG_CYCLES     = 3300000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NBTN-1:0] btn_in,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NBTN-1:0] btn_long,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [1:0]      evt_type,
  output logic [2:0]      evt_idx,
  output logic            evt_overflow
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_CYCLES - 1);
  localparam logic [NBTN-1:0] INACTIVE = {NBTN{ACTIVE_LOW}};

  localparam logic [1:0] EV_NONE  = 2'b00;
  localparam logic [1:0] EV_PRESS = 2'b01;
  localparam logic [1:0] EV_REL   = 2'b10;
  localparam logic [1:0] EV_LONG  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_PRESS_CHK, S_HELD, S_LONG, S_REL_CHK} state_t;

  logic [NBTN-1:0] sync1_q, sync2_q, active;
  logic [NBTN-1:0][1:0] slot;
  logic [NBTN-1:0] grant, drop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= INACTIVE;
      sync2_q <= INACTIVE;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign active = sync2_q ^ INACTIVE;

  for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
    state_t        state_q;
    logic [DW-1:0] dcnt_q;
    logic [HW-1:0] hcnt_q;
    logic          long_done_q, level_q, press_q, rel_q, long_q;
    logic [1:0]    slot_q, evt_d;

    // Event raised on this edge; drives both the pulse and the pending slot.
    always_comb begin
      evt_d = EV_NONE;
      case (state_q)
        S_PRESS_CHK: if (active[gi] && dcnt_q == DMAX) evt_d = EV_PRESS;
        S_HELD:      if (active[gi] && hcnt_q == HMAX) evt_d = EV_LONG;
        S_REL_CHK:   if (!active[gi] && dcnt_q == DMAX) evt_d = EV_REL;
        default:     evt_d = EV_NONE;
      endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_q     <= S_IDLE;
        dcnt_q      <= '0;
        hcnt_q      <= '0;
        long_done_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        rel_q       <= 1'b0;
        long_q      <= 1'b0;
        slot_q      <= EV_NONE;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        case (state_q)
          S_IDLE: begin
            if (active[gi]) begin
              state_q <= S_PRESS_CHK;
              dcnt_q  <= '0;
            end
          end
          S_PRESS_CHK: begin
            if (!active[gi]) begin
              state_q <= S_IDLE;
            end else if (dcnt_q == DMAX) begin
              state_q     <= S_HELD;
              level_q     <= 1'b1;
              press_q     <= 1'b1;
              hcnt_q      <= '0;
              long_done_q <= 1'b0;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
          S_HELD: begin
            if (!active[gi]) begin
              state_q <= S_REL_CHK;
              dcnt_q  <= '0;
            end else if (hcnt_q == HMAX) begin
              state_q     <= S_LONG;
              long_q      <= 1'b1;
              long_done_q <= 1'b1;
            end else begin
              hcnt_q <= hcnt_q + 1'b1;
            end
          end
          S_LONG: begin
            if (!active[gi]) begin
              state_q <= S_REL_CHK;
              dcnt_q  <= '0;
            end
          end
          S_REL_CHK: begin
            if (active[gi]) begin
              state_q <= long_done_q ? S_LONG : S_HELD;
            end else if (dcnt_q == DMAX) begin
              state_q <= S_IDLE;
              level_q <= 1'b0;
              rel_q   <= 1'b1;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase

        // A slot being drained this edge counts as free for a new event.
        if (evt_d != EV_NONE && (slot_q == EV_NONE || grant[gi]))
          slot_q <= evt_d;
        else if (grant[gi])
          slot_q <= EV_NONE;
      end
    end

    assign btn_level[gi]   = level_q;
    assign btn_press[gi]   = press_q;
    assign btn_release[gi] = rel_q;
    assign btn_long[gi]    = long_q;
    assign slot[gi]        = slot_q;
    assign drop[gi]        = (evt_d != EV_NONE) && (slot_q != EV_NONE) && !grant[gi];
  end

  logic       found, push, pop, ovf_q;
  logic [1:0] push_type;
  logic [2:0] push_idx;
  logic [2:0] cnt_q;
  logic [1:0] wr_q, rd_q;
  logic [1:0] fifo_type [4];
  logic [2:0] fifo_idx  [4];

  always_comb begin
    found     = 1'b0;
    push_type = EV_NONE;
    push_idx  = '0;
    grant     = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (!found && slot[i] != EV_NONE) begin
        found     = 1'b1;
        push_type = slot[i];
        push_idx  = 3'(i);
        grant[i]  = 1'b1;
      end
    end
    // Registered count gates the push, so a full FIFO never pushes and pops together.
    push = found && (cnt_q != 3'd4);
    if (!push) grant = '0;
  end

  assign evt_valid = (cnt_q != 3'd0);
  assign pop       = evt_valid && evt_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 3'd0;
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 2'd1;
      if (pop)  rd_q <= rd_q + 2'd1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
      if (|drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_type[wr_q] <= push_type;
      fifo_idx[wr_q]  <= push_idx;
    end
  end

  assign evt_type     = evt_valid ? fifo_type[rd_q] : 2'b00;
  assign evt_idx      = evt_valid ? fifo_idx[rd_q]  : 3'b000;
  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader: pulse timing checks plus a scoreboard of
// expected FIFO events compared as the consumer pops them.
module tb_button_reader;
  localparam int NB = 4;
  localparam int DB = 4;
  localparam int LG = 10;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [NB-1:0] btn_in = '1;
  logic          evt_ready = 1'b0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;
  logic          evt_valid, evt_overflow;
  logic [1:0]    evt_type;
  logic [2:0]    evt_idx;

  button_reader #(
    .NBTN(NB), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .resetn(resetn), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_type(evt_type), .evt_idx(evt_idx), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];
  int press_cnt[NB] = '{default: 0};
  int rel_cnt[NB]   = '{default: 0};
  int long_cnt[NB]  = '{default: 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input logic [1:0] t, input logic [2:0] idx);
    exp_q.push_back({t, idx});
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      for (int i = 0; i < NB; i++) begin
        press_cnt[i] += int'(btn_press[i]);
        rel_cnt[i]   += int'(btn_release[i]);
        long_cnt[i]  += int'(btn_long[i]);
      end
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0)
          check("sb_unexpected", {27'd0, evt_type, evt_idx}, 32'h0);
        else
          check("sb_evt", {27'd0, evt_type, evt_idx}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    step(2);
    check("rst_level", btn_level, 0);
    check("rst_press", btn_press | btn_release | btn_long, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_head", {evt_type, evt_idx}, 0);
    check("rst_ovf", evt_overflow, 0);
    resetn = 1'b1;
    step(3);

    // Clean press and release of button 0 with the consumer always ready.
    evt_ready = 1'b1;
    btn_in[0] = 1'b0;
    expect_evt(2'b01, 3'd0);
    step(6);
    check("t1_press_early", btn_press[0], 0);
    step(1);
    check("t1_press", btn_press[0], 1);
    check("t1_level", btn_level[0], 1);
    check("t1_valid_early", evt_valid, 0);
    step(1);
    check("t1_valid", evt_valid, 1);
    check("t1_head", {evt_type, evt_idx}, {2'b01, 3'd0});
    step(1);
    check("t1_popped", evt_valid, 0);
    btn_in[0] = 1'b1;
    expect_evt(2'b10, 3'd0);
    step(6);
    check("t1_rel_early", btn_release[0], 0);
    step(1);
    check("t1_rel", btn_release[0], 1);
    check("t1_level_off", btn_level[0], 0);
    step(5);

    // Bouncy press on button 1: only the final stable low run counts.
    btn_in[1] = 1'b0;
    expect_evt(2'b01, 3'd1);
    step(3);
    btn_in[1] = 1'b1;
    step(1);
    btn_in[1] = 1'b0;
    step(6);
    check("t2_press_early", btn_press[1], 0);
    step(1);
    check("t2_press", btn_press[1], 1);
    step(2);
    check("t2_press_cnt", press_cnt[1], 1);
    check("t2_rel_cnt", rel_cnt[1], 0);
    btn_in[1] = 1'b1;
    expect_evt(2'b10, 3'd1);
    step(10);
    check("t2_rel_done", rel_cnt[1], 1);

    // Long press on button 2 with a short high glitch while in LONG.
    btn_in[2] = 1'b0;
    expect_evt(2'b01, 3'd2);
    expect_evt(2'b11, 3'd2);
    step(16);
    check("t3_long_early", btn_long[2], 0);
    step(1);
    check("t3_long", btn_long[2], 1);
    step(5);
    btn_in[2] = 1'b1;
    step(2);
    btn_in[2] = 1'b0;
    step(4);
    check("t4_level_kept", btn_level[2], 1);
    check("t4_no_rel", rel_cnt[2], 0);
    step(2);
    btn_in[2] = 1'b1;
    expect_evt(2'b10, 3'd2);
    step(13);
    check("t4_rel_cnt", rel_cnt[2], 1);
    check("t4_long_cnt", long_cnt[2], 1);
    check("t4_level_off", btn_level[2], 0);

    // Simultaneous presses fill the FIFO; releases wait; a third event overflows.
    evt_ready = 1'b0;
    step(1);
    btn_in = 4'h0;
    for (int i = 0; i < NB; i++) expect_evt(2'b01, 3'(i));
    step(11);
    check("t5_valid", evt_valid, 1);
    check("t5_head", {evt_type, evt_idx}, {2'b01, 3'd0});
    btn_in = 4'hF;
    for (int i = 0; i < NB; i++) expect_evt(2'b10, 3'(i));
    step(8);
    check("t5_levels_off", btn_level, 0);
    check("t5_ovf_clear", evt_overflow, 0);
    btn_in[0] = 1'b0;
    step(6);
    check("t5_ovf_early", evt_overflow, 0);
    step(1);
    check("t5_ovf", evt_overflow, 1);
    check("t5_head_stable", {evt_type, evt_idx}, {2'b01, 3'd0});
    btn_in[0] = 1'b1;
    expect_evt(2'b10, 3'd0);
    evt_ready = 1'b1;
    step(20);
    check("t5_drained", evt_valid, 0);
    check("t5_ovf_sticky", evt_overflow, 1);
    check("t5_sb_empty", exp_q.size(), 0);

    // Reset in the middle of a debounce with two entries queued.
    evt_ready = 1'b0;
    btn_in[1:0] = 2'b00;
    step(8);
    btn_in[2] = 1'b0;
    step(4);
    check("t6_pre_valid", evt_valid, 1);
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", evt_valid, 0);
    check("t6_rst_level", btn_level, 0);
    check("t6_rst_ovf", evt_overflow, 0);
    check("t6_rst_head", {evt_type, evt_idx}, 0);
    exp_q.delete();
    step(2);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) expect_evt(2'b01, 3'(i));
    step(6);
    check("t6_press_early", btn_press, 0);
    step(1);
    check("t6_press", btn_press, 4'b0111);
    check("t6_level", btn_level, 4'b0111);
    evt_ready = 1'b1;
    btn_in = 4'hF;
    for (int i = 0; i < 3; i++) expect_evt(2'b10, 3'(i));
    step(15);
    check("t6_drained", evt_valid, 0);

    step(3);
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_reader.md
# button_reader

Debounced push-button input block for the iCEBlink40 designs. It is the input-side counterpart to the LED output blocks. It synchronises up to eight raw button pins, debounces each one with its own state machine, and reports per-button press, release and long-press pulses. The same events are also queued in a 4-entry FIFO with a valid/ready handshake, so a sequencer or LED pattern controller can consume button activity at its own pace.

## Interface
- NBTN, 4: number of buttons, 1..8.
- DEBOUNCE_CYCLES, 33000: number of stable cycles needed to accept a level change (10 ms at 3.3 MHz); must be ≥ 2.
- LONG_CYCLES, 3300000: number of held cycles after an accepted press before a long-press event fires (1 s); must be ≥ 2.
- ACTIVE_LOW, 1: 1 means a raw pin reads 0 when the button is pressed.

Ports:
- clk  in  1  single system clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- btn_in  in  NBTN  raw, asynchronous button pins.
- btn_level  out  NBTN  debounced pressed level; 1 = pressed.
- btn_press  out  NBTN  one-cycle pulse when a press is accepted.
- btn_release  out  NBTN  one-cycle pulse when a release is accepted.
- btn_long  out  NBTN  one-cycle pulse when a long press fires (at most once per press).
- evt_valid  out  1  FIFO is not empty.
- evt_ready  in  1  consumer accepts the head entry.
- evt_type  out  2  type of the head entry: 01 press, 10 release, 11 long.
- evt_idx  out  3  button index of the head entry.
- evt_overflow  out  1  sticky flag: an event was dropped.

## Operation
- Raw input path: each pin passes through a 2-FF synchroniser. "Active" means the synchronised value, XORed with ACTIVE_LOW, equals 1.
- Each button has its own FSM with states IDLE, PRESS_CHK, HELD, LONG and REL_CHK. Each button has a debounce counter `dcnt`, a hold counter `hcnt` and a `long_done` bit.
- IDLE:
  - If active, go to PRESS_CHK with dcnt = 0.
- PRESS_CHK:
  - If inactive, return to IDLE.
  - Else, if dcnt == DEBOUNCE_CYCLES-1, go to HELD. On that transition: btn_level = 1, pulse btn_press, hcnt = 0, long_done = 0.
  - Else dcnt++.
- HELD:
  - If inactive, go to REL_CHK with dcnt = 0.
  - Else, if hcnt == LONG_CYCLES-1, go to LONG, pulse btn_long and set long_done = 1.
  - Else hcnt++.
- LONG:
  - If inactive, go to REL_CHK with dcnt = 0.
- REL_CHK:
  - hcnt is frozen in this state.
  - If active, return to LONG when long_done = 1, else to HELD. No pulse is produced.
  - Else, if dcnt == DEBOUNCE_CYCLES-1, go to IDLE with btn_level = 0 and pulse btn_release.
  - Else dcnt++.
- Event pending slots:
  - Each button has a 1-entry pending slot holding an event type.
  - The slot loads on the same edge as the corresponding pulse.
  - If the slot is already occupied when a new event arrives, the new event is dropped and evt_overflow is set.
- Arbiter and FIFO:
  - Each cycle in which the FIFO count is below 4 (registered count), the arbiter pushes the lowest-index occupied slot into the FIFO and clears that slot.
  - At most one push per cycle.
- FIFO pop:
  - The FIFO pops when evt_valid && evt_ready.
  - When the FIFO is full, a pop and a push may not occur in the same cycle; the push waits one cycle.
  - evt_type and evt_idx are held stable while evt_valid is high and evt_ready is low.
- evt_overflow is cleared only by reset.

## Timing
- Reset (asynchronous assertion, synchronous release):
  - All FSMs are in IDLE; synchronisers are loaded with the inactive value.
  - dcnt, hcnt, long_done and pending slots are all 0; the FIFO is empty.
  - All outputs are 0.
- Reset asserted mid-operation aborts any in-progress debounce and discards the FIFO contents.
- Press latency: let t0 be the edge at which synchroniser stage 1 first captures the active level, with the input then held stable.
  - btn_press and btn_level rise after edge t0+DEBOUNCE_CYCLES+2.
  - evt_valid rises after edge t0+DEBOUNCE_CYCLES+3, provided the FIFO and the arbiter are free.
- Release latency follows the same formula measured from the first inactive capture.
- Long press: btn_long pulses LONG_CYCLES edges after the edge at which HELD was entered, excluding any edges spent in REL_CHK.
- Any glitch shorter than DEBOUNCE_CYCLES restarts the count; no pulse is produced.
- Counters never wrap. Counter widths are clog2(DEBOUNCE_CYCLES) and clog2(LONG_CYCLES) respectively.
- Simultaneous events on several buttons occupy separate slots and drain one per cycle in index order.

## Test plan
Directed tests use DEBOUNCE_CYCLES = 4, LONG_CYCLES = 10 and ACTIVE_LOW = 1.

1. Drive btn_in[0] low cleanly at t0 → btn_press[0] pulses after edge t0+6. evt_valid rises after t0+7 with type 01 and idx 0. Hold evt_ready high → the entry pops and evt_valid falls.
2. Bounce btn_in[1] low for 3 cycles, high for 1, then low steadily → exactly one press, counted from the last falling transition. No release event.
3. Hold btn_in[2] low for 30 cycles, then release → the sequence press, long (10 edges after HELD is entered), release. FIFO entries in order: 01/2, 11/2, 10/2.
4. In the LONG state, glitch btn_in[2] high for 2 cycles → the FSM returns to LONG. No release pulse and no second long pulse.
5. Press buttons 0–3 on the same edge with evt_ready low → four FIFO entries in idx order 0, 1, 2, 3. Release all while evt_ready is still low → release events wait in their pending slots. One more event on button 0 → evt_overflow = 1.
6. Assert resetn low mid-PRESS_CHK with the FIFO holding 2 entries → all outputs and evt_valid are 0 immediately. After resetn is released, a held button produces a fresh press after the full latency.
